// File: rtl/ad_stats_pkg.sv
// Shared sizing constants and FSM state type for the frame statistics block.
package ad_stats_pkg;

    localparam int unsigned N_SAMPLES = 64;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned SUM_W     = 22;
    localparam int unsigned FRAME_W   = N_SAMPLES * SAMPLE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ad_frame_stats.sv
// Per-frame statistics (sum, mean, min, max, peak-to-peak) over 64 ADC samples,
// one sample per clock from a captured copy of the frame.
module ad_frame_stats
    import ad_stats_pkg::*;
#(
    parameter int TWOS_COMP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FRAME_W-1:0]  ads_frame,
    input  logic                sample_done,
    input  logic                ovr_clr,
    output logic [SAMPLE_W-1:0] stats_mean,
    output logic [SAMPLE_W-1:0] stats_min,
    output logic [SAMPLE_W-1:0] stats_max,
    output logic [SAMPLE_W:0]   stats_p2p,
    output logic [SUM_W-1:0]    stats_sum,
    output logic                stats_valid,
    output logic                busy,
    output logic                overrun
);

    state_t                      state_q, state_d;
    logic                        sd_q;
    logic                        sd_rise;
    logic [FRAME_W-1:0]          frame_q, frame_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [SUM_W-1:0]     sum_q, sum_d;
    logic signed [SAMPLE_W-1:0]  min_q, min_d;
    logic signed [SAMPLE_W-1:0]  max_q, max_d;
    logic signed [SAMPLE_W-1:0]  samp;

    logic [SAMPLE_W-1:0]         mean_q, mean_d;
    logic [SAMPLE_W-1:0]         omin_q, omin_d;
    logic [SAMPLE_W-1:0]         omax_q, omax_d;
    logic [SAMPLE_W:0]           p2p_q, p2p_d;
    logic [SUM_W-1:0]            osum_q, osum_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        overrun_q, overrun_d;

    assign sd_rise = sample_done & ~sd_q;

    // Offset-binary input becomes two's complement by flipping the MSB.
    always_comb begin
        samp = frame_q[{idx_q, 4'b0000} +: SAMPLE_W];
        if (TWOS_COMP == 0) begin
            samp[SAMPLE_W-1] = ~samp[SAMPLE_W-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        mean_d    = mean_q;
        omin_d    = omin_q;
        omax_d    = omax_q;
        p2p_d     = p2p_q;
        osum_d    = osum_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sd_rise) begin
                    frame_d = ads_frame;
                    sum_d   = '0;
                    min_d   = {1'b0, {(SAMPLE_W-1){1'b1}}};
                    max_d   = {1'b1, {(SAMPLE_W-1){1'b0}}};
                    idx_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                sum_d = sum_q + {{(SUM_W-SAMPLE_W){samp[SAMPLE_W-1]}}, samp};
                if (samp < min_q) begin
                    min_d = samp;
                end
                if (samp > max_q) begin
                    max_d = samp;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_SAMPLES-1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Taking the top 16 bits is an arithmetic shift by 6 (floor).
                mean_d  = sum_q[SUM_W-1 -: SAMPLE_W];
                omin_d  = min_q;
                omax_d  = max_q;
                p2p_d   = {max_q[SAMPLE_W-1], max_q} - {min_q[SAMPLE_W-1], min_q};
                osum_d  = sum_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sd_rise && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sd_q      <= 1'b0;
            frame_q   <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            mean_q    <= '0;
            omin_q    <= '0;
            omax_q    <= '0;
            p2p_q     <= '0;
            osum_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sd_q      <= sample_done;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            mean_q    <= mean_d;
            omin_q    <= omin_d;
            omax_q    <= omax_d;
            p2p_q     <= p2p_d;
            osum_q    <= osum_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign stats_mean  = mean_q;
    assign stats_min   = omin_q;
    assign stats_max   = omax_q;
    assign stats_p2p   = p2p_q;
    assign stats_sum   = osum_q;
    assign stats_valid = valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ad_frame_stats.sv
// Randomized scoreboard bench: two instances (two's complement and offset binary)
// share stimulus; a monitor pops expected stats whenever stats_valid is seen.
module tb_ad_frame_stats;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] ads_frame;
    logic          sample_done;
    logic          ovr_clr;

    logic [15:0] m_a, mn_a, mx_a, m_b, mn_b, mx_b;
    logic [16:0] p_a, p_b;
    logic [21:0] s_a, s_b;
    logic        v_a, b_a, o_a, v_b, b_b, o_b;

    always #5 clk = ~clk;

    ad_frame_stats #(.TWOS_COMP(1)) dut (
        .clk(clk), .rst(rst), .ads_frame(ads_frame), .sample_done(sample_done),
        .ovr_clr(ovr_clr), .stats_mean(m_a), .stats_min(mn_a), .stats_max(mx_a),
        .stats_p2p(p_a), .stats_sum(s_a), .stats_valid(v_a), .busy(b_a), .overrun(o_a)
    );

    ad_frame_stats #(.TWOS_COMP(0)) dut_ob (
        .clk(clk), .rst(rst), .ads_frame(ads_frame), .sample_done(sample_done),
        .ovr_clr(ovr_clr), .stats_mean(m_b), .stats_min(mn_b), .stats_max(mx_b),
        .stats_p2p(p_b), .stats_sum(s_b), .stats_valid(v_b), .busy(b_b), .overrun(o_b)
    );

    typedef struct {
        int mean;
        int mn;
        int mx;
        int p2p;
        int sum;
    } st_t;

    typedef struct {
        st_t tc;
        st_t ob;
        int  cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic st_t model(input logic [1023:0] f, input bit tc);
        st_t r;
        logic [15:0] raw;
        int v;
        r.sum = 0;
        r.mn  = 32767;
        r.mx  = -32768;
        for (int k = 0; k < 64; k++) begin
            raw = f[k*16 +: 16];
            v = tc ? int'($signed(raw)) : int'(raw) - 32768;
            r.sum += v;
            if (v < r.mn) r.mn = v;
            if (v > r.mx) r.mx = v;
        end
        if (r.sum >= 0) r.mean = r.sum / 64;
        else            r.mean = -((-r.sum + 63) / 64);
        r.p2p = r.mx - r.mn;
        return r;
    endfunction

    function automatic logic [1023:0] rand_frame();
        logic [1023:0] f;
        for (int k = 0; k < 64; k++) begin
            case ($urandom_range(0, 3))
                0:       f[k*16 +: 16] = 16'h8000;
                1:       f[k*16 +: 16] = 16'h7FFF;
                default: f[k*16 +: 16] = 16'($urandom());
            endcase
        end
        return f;
    endfunction

    function automatic logic [1023:0] fill_frame(input logic [15:0] s);
        logic [1023:0] f;
        for (int k = 0; k < 64; k++) f[k*16 +: 16] = s;
        return f;
    endfunction

    task automatic chk_stats(input string tag, input st_t e, input logic [15:0] m,
                             input logic [15:0] mn, input logic [15:0] mx,
                             input logic [16:0] p, input logic [21:0] s);
        chk({tag, "_mean"}, int'($signed(m)), e.mean);
        chk({tag, "_min"},  int'($signed(mn)), e.mn);
        chk({tag, "_max"},  int'($signed(mx)), e.mx);
        chk({tag, "_p2p"},  int'(p), e.p2p);
        chk({tag, "_sum"},  int'($signed(s)), e.sum);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mean"},  int'(m_a), 0);
        chk({tag, "_min"},   int'(mn_a), 0);
        chk({tag, "_max"},   int'(mx_a), 0);
        chk({tag, "_p2p"},   int'(p_a), 0);
        chk({tag, "_sum"},   int'(s_a), 0);
        chk({tag, "_valid"}, int'(v_a), 0);
        chk({tag, "_busy"},  int'(b_a), 0);
        chk({tag, "_ovr"},   int'(o_a), 0);
    endtask

    // Monitor: compare whenever either instance presents a result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (v_a || v_b) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("valid_tc", int'(v_a), 1);
                    chk("valid_ob", int'(v_b), 1);
                    chk_stats("tc", e.tc, m_a, mn_a, mx_a, p_a, s_a);
                    chk_stats("ob", e.ob, m_b, mn_b, mx_b, p_b, s_b);
                end
            end
        end
    end

    // mode: 0 normal, 1 overrun in ACC, 2 reset abort, 3 overrun+clr same edge, 4 overrun in DONE
    task automatic run_frame(input logic [1023:0] f, input int mode);
        exp_t e;
        e.tc  = model(f, 1'b1);
        e.ob  = model(f, 1'b0);
        e.cyc = cyc + 1 + 65;
        if (mode != 2) q.push_back(e);
        ads_frame   = f;
        sample_done = 1'b1;
        for (int k = 0; k <= 66; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("busy_start", int'(b_a), 1);
                chk("overrun_idle", int'(o_a), 0);
                sample_done = 1'b0;
                ads_frame   = rand_frame();
            end
            if (mode == 1) begin
                if (k == 29) begin sample_done = 1'b1; ads_frame = rand_frame(); end
                if (k == 30) begin chk("overrun_acc", int'(o_a), 1); sample_done = 1'b0; end
                if (k == 40) ovr_clr = 1'b1;
                if (k == 41) begin chk("overrun_clr", int'(o_a), 0); ovr_clr = 1'b0; end
            end
            if (mode == 3) begin
                if (k == 10) begin sample_done = 1'b1; ovr_clr = 1'b1; end
                if (k == 11) begin chk("overrun_set_wins", int'(o_a), 1); sample_done = 1'b0; ovr_clr = 1'b0; end
                if (k == 12) ovr_clr = 1'b1;
                if (k == 13) begin chk("overrun_clr2", int'(o_a), 0); ovr_clr = 1'b0; end
            end
            if (mode == 4) begin
                if (k == 64) sample_done = 1'b1;
                if (k == 65) begin chk("overrun_done", int'(o_a), 1); sample_done = 1'b0; ovr_clr = 1'b1; end
                if (k == 66) begin chk("overrun_clr3", int'(o_a), 0); ovr_clr = 1'b0; end
            end
            if (mode == 2 && k == 20) begin
                rst = 1'b1;
                #1;
                chk_zero("rst_mid");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == 64) chk("busy_last", int'(b_a), 1);
            if (k == 65) begin
                chk("busy_end", int'(b_a), 0);
                chk("valid_at_65", int'(v_a), 1);
            end
            if (k == 66) begin
                chk("valid_one_cycle", int'(v_a), 0);
                chk("hold_mean", int'($signed(m_a)), e.tc.mean);
                chk("hold_sum", int'($signed(s_a)), e.tc.sum);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1023:0] f;
        rst         = 1'b1;
        sample_done = 1'b0;
        ovr_clr     = 1'b0;
        ads_frame   = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_frame(fill_frame(16'hAAAA), 0);
        for (int k = 0; k < 64; k++) f[k*16 +: 16] = 16'(k);
        run_frame(f, 0);
        f = fill_frame(16'h8000);
        f[15:0] = 16'h7FFF;
        run_frame(f, 0);
        run_frame(fill_frame(16'h8000), 0);
        run_frame(rand_frame(), 1);
        run_frame(rand_frame(), 3);
        run_frame(rand_frame(), 4);
        run_frame(rand_frame(), 2);
        chk("busy_after_rst", int'(b_a), 0);
        run_frame(rand_frame(), 0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(rand_frame(), 0);
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ad_frame_stats.md
AD_FRAME_STATS -- requirements
Module: ad_frame_stats

Interface
REQ-001 Parameter TWOS_COMP, default 1, meaning: 1 = samples are two's complement (AD7606 default); 0 = offset binary, converted by inverting bit 15 before use.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ads_frame  input  1024  64 samples from the acquisition stage, {ads_data_64,...,ads_data_1}; sample k occupies bits [16k+15:16k], k = 0..63.
REQ-005 sample_done  input  1  frame-complete strobe from the acquisition stage; rising edge is the event.
REQ-006 ovr_clr  input  1  synchronous clear of overrun.
REQ-007 stats_mean  output  16  signed mean of frame.
REQ-008 stats_min  output  16  signed minimum sample.
REQ-009 stats_max  output  16  signed maximum sample.
REQ-010 stats_p2p  output  17  unsigned max minus min.
REQ-011 stats_sum  output  22  signed sum of 64 samples.
REQ-012 stats_valid  output  1  one-cycle pulse; stats outputs updated this cycle.
REQ-013 busy  output  1  high while a frame is being processed.
REQ-014 overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-015 sample_done SHALL be edge-detected against a registered copy; a held-high level counts as one event.
REQ-016 States SHALL be IDLE, ACC, DONE.
- IDLE: on rising edge at clock edge N, copy ads_frame into an internal 1024-bit frame register, clear accumulators (sum=0, min=+32767, max=-32768), idx=0, go to ACC.
- ACC: at each edge N+1..N+64, process sample idx, increment idx; after idx=63, go to DONE.
- DONE: at edge N+65, register outputs, assert stats_valid for exactly one cycle, return to IDLE.
REQ-017 Latency SHALL be fixed: stats_valid high in the cycle after edge N+65; busy high from edge N through edge N+65.
REQ-018 Sum SHALL be 22-bit signed, sign-extended per sample; no overflow possible.
REQ-019 stats_mean SHALL be sum arithmetically shifted right by 6 (floor toward minus infinity), low 16 bits.
REQ-020 stats_p2p SHALL be max minus min computed in 17 bits, range 0..65535.
REQ-021 With TWOS_COMP=0, every sample SHALL be MSB-inverted before all arithmetic; outputs remain two's complement.
REQ-022 A sample_done rising edge while in ACC or DONE SHALL NOT restart or alter the current frame; the new frame is dropped and overrun set.
REQ-023 ovr_clr clears overrun next edge; simultaneous new overrun and ovr_clr: set wins.
REQ-024 Stats outputs SHALL hold last values between stats_valid pulses.
REQ-025 Frame register SHALL isolate processing from ads_frame changes after edge N.

Reset
REQ-026 rst SHALL asynchronously force IDLE, idx=0, all outputs 0 (stats_*, stats_valid, busy, overrun), edge-detect register 0.
REQ-027 rst asserted mid-frame SHALL abort it with no stats_valid; the first sample_done rising edge after release SHALL be processed normally.

Structure
REQ-028 Package ad_stats_pkg SHALL hold N_SAMPLES=64, IDX_W=6, SAMPLE_W=16, SUM_W=22, and the state enumeration.
REQ-029 No sub-module; single module with inline sample selection by idx.

Verification
REQ-030 All samples 0xAAAA, TWOS_COMP=1 -> mean=min=max=-21846, sum=-1398144, p2p=0, stats_valid one cycle at N+65.
REQ-031 Ramp sample k=k (0..63) -> sum=2016, mean=31, min=0, max=63, p2p=63.
REQ-032 Sample 0=0x7FFF, others 0x8000 -> min=-32768, max=32767, p2p=65535, sum=-2031617, mean=-31745.
REQ-033 Second sample_done rise at N+30 -> overrun=1, single stats_valid at N+65 from first frame; ovr_clr -> overrun=0.
REQ-034 rst pulse at N+20 -> all outputs 0 immediately, no stats_valid; next sample_done gives correct stats 65 cycles later.
REQ-035 TWOS_COMP=0, all samples 0x8000 -> mean=min=max=0, sum=0, p2p=0.
